mips_bus_arbiter: RTL and testbench



---
 rtl/mips_bus_arbiter.sv | 77 +++++++
 tb/tb_mips_bus_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: serialises core fetch (instr_*) and data (data_*) accesses onto one waitstate bus (bus_*), raising stall until all accesses of the core cycle complete
module mips_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    instr_req,
  input  logic [ADDR_WIDTH-1:0]   instr_address,
  output logic [DATA_WIDTH-1:0]   instr_readdata,
  input  logic                    data_read,
  input  logic                    data_write,
  input  logic [ADDR_WIDTH-1:0]   data_address,
  input  logic [DATA_WIDTH-1:0]   data_writedata,
  input  logic [DATA_WIDTH/8-1:0] data_byteenable,
  output logic [DATA_WIDTH-1:0]   data_readdata,
  output logic                    stall,
  output logic [ADDR_WIDTH-1:0]   bus_address,
  output logic                    bus_read,
  output logic                    bus_write,
  output logic [DATA_WIDTH-1:0]   bus_writedata,
  output logic [DATA_WIDTH/8-1:0] bus_byteenable,
  input  logic                    bus_waitrequest,
  input  logic [DATA_WIDTH-1:0]   bus_readdata
);
  typedef enum logic {ARB, XFER} state_t;
  state_t state;
  logic data_done, instr_done, sel_data;
  logic data_pend, instr_pend, pick_data, data_wr;
  assign data_pend  = (data_read | data_write) & ~data_done;
  assign instr_pend = instr_req & ~instr_done;
  assign pick_data  = DATA_FIRST ? data_pend : data_pend & ~instr_pend;
  assign data_wr    = pick_data & data_write;
  assign stall      = (state == XFER) | instr_pend | data_pend;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state          <= ARB;
      data_done      <= 1'b0;
      instr_done     <= 1'b0;
      sel_data       <= 1'b0;
      bus_address    <= '0;
      bus_read       <= 1'b0;
      bus_write      <= 1'b0;
      bus_writedata  <= '0;
      bus_byteenable <= '0;
      instr_readdata <= '0;
      data_readdata  <= '0;
    end else if (state == ARB) begin
      if (data_pend | instr_pend) begin
        state          <= XFER;
        sel_data       <= pick_data;
        bus_address    <= pick_data ? data_address : instr_address;
        bus_read       <= ~data_wr;
        bus_write      <= data_wr;
        bus_writedata  <= data_wr ? data_writedata : '0;
        bus_byteenable <= pick_data ? data_byteenable : '1;
      end else begin
        data_done  <= 1'b0;
        instr_done <= 1'b0;
      end
    end else if (!bus_waitrequest) begin
      state          <= ARB;
      bus_address    <= '0;
      bus_read       <= 1'b0;
      bus_write      <= 1'b0;
      bus_writedata  <= '0;
      bus_byteenable <= '0;
      if (sel_data) begin
        data_done <= 1'b1;
        if (bus_read) data_readdata <= bus_readdata;
      end else begin
        instr_done <= 1'b1;
        if (bus_read) instr_readdata <= bus_readdata;
      end
    end
endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb_mips_bus_arbiter: scoreboard bench running data-first and fetch-first arbiters side by side
module tb_mips_bus_arbiter;
  typedef struct packed {
    logic [31:0] addr;
    logic        r;
    logic        w;
    logic [31:0] wdat;
    logic [3:0]  ben;
  } xfer_t;
  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] dr;
  } commit_t;
  logic clk, reset, instr_req, data_read, data_write, wreq;
  logic [31:0] instr_address, data_address, data_writedata;
  logic [3:0] data_byteenable;
  logic [31:0] b_addr[2], b_wd[2], b_rdata[2], ird[2], drd[2];
  logic [3:0] b_be[2];
  logic b_rd[2], b_wr[2], stl[2];
  xfer_t q0[$], q1[$], cur[2];
  commit_t cq[$];
  int wq[$];
  int errors = 0, checks = 0;
  logic [31:0] m_ir, m_dr;
  bit prev[2];
  function automatic logic [31:0] rdf(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'h24020005;
  endfunction
  assign b_rdata[0] = rdf(b_addr[0]);
  assign b_rdata[1] = rdf(b_addr[1]);
  mips_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DATA_FIRST(1'b1)) u_df (
    .clk(clk), .reset(reset), .instr_req(instr_req), .instr_address(instr_address),
    .instr_readdata(ird[0]), .data_read(data_read), .data_write(data_write),
    .data_address(data_address), .data_writedata(data_writedata),
    .data_byteenable(data_byteenable), .data_readdata(drd[0]), .stall(stl[0]),
    .bus_address(b_addr[0]), .bus_read(b_rd[0]), .bus_write(b_wr[0]),
    .bus_writedata(b_wd[0]), .bus_byteenable(b_be[0]), .bus_waitrequest(wreq),
    .bus_readdata(b_rdata[0]));
  mips_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DATA_FIRST(1'b0)) u_if (
    .clk(clk), .reset(reset), .instr_req(instr_req), .instr_address(instr_address),
    .instr_readdata(ird[1]), .data_read(data_read), .data_write(data_write),
    .data_address(data_address), .data_writedata(data_writedata),
    .data_byteenable(data_byteenable), .data_readdata(drd[1]), .stall(stl[1]),
    .bus_address(b_addr[1]), .bus_read(b_rd[1]), .bus_write(b_wr[1]),
    .bus_writedata(b_wd[1]), .bus_byteenable(b_be[1]), .bus_waitrequest(wreq),
    .bus_readdata(b_rdata[1]));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  // Bus slave: each new transfer takes the next wait count from wq; both DUTs move in lockstep
  initial begin
    bit busy;
    int wcnt;
    busy = 0;
    wcnt = 0;
    wreq = 0;
    forever begin
      @(posedge clk);
      #1;
      if (b_rd[0] | b_wr[0]) begin
        if (!busy) begin
          busy = 1;
          wcnt = wq.size() > 0 ? wq.pop_front() : 0;
        end else if (wcnt > 0) wcnt--;
        wreq = wcnt > 0;
      end else begin
        busy = 0;
        wreq = 1'($urandom_range(0, 1));
      end
    end
  end
  task automatic chk_bus(input int d, input string tag);
    xfer_t g;
    g = '{addr: b_addr[d], r: b_rd[d], w: b_wr[d], wdat: (cur[d].w ? b_wd[d] : 32'h0), ben: b_be[d]};
    checks++;
    if (g != cur[d]) begin
      errors++;
      $display("FAIL %s dut%0d got=%h exp=%h", tag, d, g, cur[d]);
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  initial begin
    commit_t ce;
    logic s;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev[0] = 0;
        prev[1] = 0;
      end else begin
        for (int d = 0; d < 2; d++) begin
          s = b_rd[d] | b_wr[d];
          if (s && !prev[d]) begin
            if ((d == 0 ? q0.size() : q1.size()) == 0) begin
              checks++;
              errors++;
              $display("FAIL xfer_unexpected dut%0d got=%h exp=none", d, b_addr[d]);
            end else begin
              if (d == 0) cur[0] = q0.pop_front();
              else cur[1] = q1.pop_front();
              chk_bus(d, "xfer_start");
            end
          end else if (s) chk_bus(d, "xfer_stable");
          else chk($sformatf("idle_bus dut%0d", d), b_addr[d] | b_wd[d] | 32'(b_be[d]), 32'h0);
          prev[d] = s;
        end
        if (!stl[0] || !stl[1]) begin
          if (cq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL commit_unexpected got=stall_low exp=stall_high");
          end else begin
            ce = cq.pop_front();
            for (int d = 0; d < 2; d++) begin
              checks++;
              if ({stl[d], ird[d], drd[d]} !== {1'b0, ce.ir, ce.dr}) begin
                errors++;
                $display("FAIL commit dut%0d got=%b/%h/%h exp=0/%h/%h", d, stl[d], ird[d], drd[d], ce.ir, ce.dr);
              end
            end
          end
        end
      end
    end
  end
  // One core cycle: queue expected transfers per arbitration order, hold values and latency, then drive
  task automatic run_txn(input bit ir, rd, wr, input logic [31:0] ia, da, wd,
                         input logic [3:0] be, input int w1, w2, input bit pert, rel);
    xfer_t xd, xi;
    bit dv;
    int n, lat, cyc;
    dv = rd | wr;
    xd = '{addr: da, r: !wr, w: wr, wdat: (wr ? wd : 32'h0), ben: be};
    xi = '{addr: ia, r: 1'b1, w: 1'b0, wdat: 32'h0, ben: 4'hF};
    if (dv) q0.push_back(xd);
    if (ir) q0.push_back(xi);
    if (ir) q1.push_back(xi);
    if (dv) q1.push_back(xd);
    n = int'(dv) + int'(ir);
    if (n >= 1) wq.push_back(w1);
    if (n == 2) wq.push_back(w2);
    lat = 1 + 2 * n + (n >= 1 ? w1 : 0) + (n == 2 ? w2 : 0);
    if (ir) m_ir = rdf(ia);
    if (rd && !wr) m_dr = rdf(da);
    cq.push_back('{ir: m_ir, dr: m_dr});
    instr_req = ir;
    data_read = rd;
    data_write = wr;
    instr_address = ia;
    data_address = da;
    data_writedata = wd;
    data_byteenable = be;
    if (rel) reset = 0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (pert && cyc == 3) data_address = ~da;
    end while (stl[0] && stl[1] && cyc < 60);
    checks++;
    if (cyc != lat) begin
      errors++;
      $display("FAIL latency got=%0d exp=%0d", cyc, lat);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    m_ir = 0;
    m_dr = 0;
    reset = 0;
    instr_req = 0;
    data_read = 0;
    data_write = 0;
    instr_address = 0;
    data_address = 0;
    data_writedata = 0;
    data_byteenable = 0;
    #1 reset = 1;
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("rst_bus", b_addr[d] | b_wd[d] | 32'(b_be[d]) | 32'(b_rd[d]) | 32'(b_wr[d]), 32'h0);
      chk("rst_hold", ird[d] | drd[d], 32'h0);
      chk("rst_stall_idle", 32'(stl[d]), 32'h0);
    end
    instr_req = 1;
    #1;
    chk("rst_stall_req", 32'(stl[0] & stl[1]), 32'h1);
    instr_req = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    run_txn(1, 0, 0, 32'hBFC00000, 0, 0, 4'h0, 0, 0, 0, 1);
    run_txn(1, 0, 1, 32'hBFC00004, 32'h100, 32'hCAFEF00D, 4'b0011, 0, 0, 0, 0);
    run_txn(0, 1, 0, 0, 32'h2000, 0, 4'hF, 4, 0, 1, 0);
    data_read = 1;
    data_address = 32'h3000;
    data_byteenable = 4'hF;
    q0.push_back('{addr: 32'h3000, r: 1'b1, w: 1'b0, wdat: 32'h0, ben: 4'hF});
    q1.push_back('{addr: 32'h3000, r: 1'b1, w: 1'b0, wdat: 32'h0, ben: 4'hF});
    wq.push_back(5);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_mid_strobe", 32'(b_rd[d] | b_wr[d]), 32'h0);
      chk("rst_mid_hold", ird[d] | drd[d], 32'h0);
      chk("rst_mid_stall", 32'(stl[d]), 32'h1);
    end
    q0.delete();
    q1.delete();
    wq.delete();
    cq.delete();
    m_ir = 0;
    m_dr = 0;
    @(posedge clk);
    #1;
    run_txn(0, 1, 0, 0, 32'h3000, 0, 4'hF, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) run_txn(1, 0, 0, 32'h400 + 4 * i, 0, 0, 4'h0, 0, 0, 0, 0);
    run_txn(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    run_txn(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    for (int i = 0; i < 80; i++) begin
      int k;
      k = $urandom_range(0, 3);
      run_txn(1'($urandom_range(0, 1)), k == 1 || k == 3, k >= 2, $urandom, $urandom, $urandom,
              4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
